mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined unsigned multiplier among N_REQ requesters.
- Each requester owns a private accumulator, so the block gives every requester a virtual multiply/multiply-accumulate unit.
- Sits between requester datapaths (shift/filter blocks) and the single multiplier resource.
- Issues at most one operation per cycle; each result returns tagged with its requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID width IDW = clog2(N_REQ).
- WIDTH, 8, operand width in bits.
- PIPE, 3, cycles from grant to result (>=2); includes operand capture and multiplier stages.
- ACCW, 20, accumulator width (>= 2*WIDTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request per requester; held high with operands stable until granted.
- a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- b  in  N_REQ*WIDTH  operand B, same packing.
- accum  in  N_REQ  per requester: 1 = add product into accumulator, 0 = load accumulator with product.
- gnt  out  N_REQ  one-hot grant, combinational, this cycle.
- busy  out  1  high while any operation is in flight.
- rsp_valid  out  1  result valid strobe, one cycle per operation.
- rsp_id  out  IDW  requester that issued the returning operation.
- rsp_product  out  2*WIDTH  raw product a*b.
- rsp_acc  out  ACCW  updated accumulator value of rsp_id.

Behaviour:
- Reset (reset_n low, asynchronous, any time):
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_acc=0, busy=0.
  - All accumulators cleared to 0; priority pointer set to 0.
  - Pipeline flushed: ops in flight at reset are lost and never reported.
  - Block leaves reset on the first rising clk edge after reset_n goes high.
- Arbitration:
  - gnt is combinational from req and the pointer, and is one-hot or zero.
  - Scan runs from the pointer upward, wrapping modulo N_REQ; the first set req wins.
  - When gnt[i] is high, the pointer moves to (i+1) mod N_REQ at the clock edge.
  - With no request, gnt=0 and the pointer holds.
- Handshake:
  - Transfer happens on the edge where req[i]&gnt[i]; a[i], b[i] and accum[i] are captured on that edge.
  - The requester may hold req high for the next operation.
  - A requester holding req continuously gets at most 1 grant per N_REQ cycles while others request, and every cycle when alone.
  - Dropping req before it is granted is allowed; no operation is issued.
- Pipeline:
  - Captured {id, a, b, accum, valid} advance one stage per cycle, with no stalls.
  - rsp_valid is asserted exactly PIPE cycles after the grant edge, in issue order.
  - Throughput is 1 op/cycle.
- Arithmetic:
  - rsp_product = a*b, unsigned, full 2*WIDTH bits, never truncated.
  - Writeback at the final stage:
    - accum=1: acc[id] <= acc[id] + zero-extended product, wrapping modulo 2^ACCW with no saturation or flag.
    - accum=0: acc[id] <= product.
  - rsp_acc shows the new value in the same cycle as rsp_valid.
- Hazards:
  - Accumulator read-modify-write happens only at writeback, so back-to-back ops from one requester chain correctly with no bubble.
- busy:
  - busy = OR of all stage valids, including the capture stage.
  - busy goes high the cycle after the first grant.
  - busy goes low the cycle after the last rsp_valid.
- Outputs when rsp_valid=0: rsp_id, rsp_product and rsp_acc hold their last values.

Test Plan:
- Reset and single op:
  - Stimulus: reset_n low 2 cycles; then req=0001, a0=8'd12, b0=8'd10, accum0=0.
  - Required: gnt=0001 at once; rsp_valid exactly 3 cycles later with rsp_id=0, rsp_product=120, rsp_acc=120; busy high for 3 cycles.
- Round-robin fairness:
  - Stimulus: req=1111 held 8 cycles.
  - Required: gnt sequence 0001,0010,0100,1000,0001,...; 8 rsp_valid pulses with rsp_id order 0,1,2,3,0,1,2,3.
- Back-to-back accumulate:
  - Stimulus: requester 2 alone, 4 consecutive ops a=255, b=255, accum=0,1,1,1.
  - Required: gnt every cycle; rsp_acc = 65025, 130050, 195075, 260100.
- Accumulator wrap:
  - Stimulus: ACCW=20, acc1 preloaded to 1040000 via accum=0 ops, then one accum=1 op of 255*255.
  - Required: rsp_acc = (1040000+65025) mod 1048576 = 56449.
- Mid-operation reset:
  - Stimulus: reset_n pulsed low for 1 cycle with 3 ops in flight.
  - Required: no rsp_valid for the flushed ops; all accumulators read 0 (next accum=1 op of 3*4 returns rsp_acc=12); pointer back at 0.
- Withdrawn request and pointer hold:
  - Stimulus: req=0110 with pointer=0.
  - Required: gnt=0010 first; if req[2] then drops before its grant, no op is issued for requester 2, pointer=2 holds, and the next req=0001 is granted.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters,
// each with a private accumulator written back at the final stage.
module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int PIPE  = 3,
  parameter int ACCW  = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WIDTH-1:0]      a,
  input  logic [N_REQ*WIDTH-1:0]      b,
  input  logic [N_REQ-1:0]            accum,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic                        rsp_valid,
  output logic [$clog2(N_REQ)-1:0]    rsp_id,
  output logic [2*WIDTH-1:0]          rsp_product,
  output logic [ACCW-1:0]             rsp_acc
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = 2 * WIDTH;
  localparam int NS  = PIPE - 1;

  typedef struct packed {
    logic             v;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
    logic [PW-1:0]    prod;
  } stage_t;

  logic           found;
  logic           hit;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] ptr;

  stage_t         cap;
  stage_t         wb;
  stage_t         st [NS];
  stage_t         nx [NS];

  logic [PW-1:0]   mul0;
  logic [PW-1:0]   wb_prod;
  logic [ACCW-1:0] acc [N_REQ];
  logic [ACCW-1:0] acc_new;

  // Scan upward from the pointer, wrapping; first set request wins.
  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      p = (int'(ptr) + k) % N_REQ;
      if (!found && req[p]) begin
        found = 1'b1;
        sel   = IDW'(p);
      end
    end
  end

  assign hit = found & reset_n;

  always_comb begin
    gnt = '0;
    if (hit) gnt[sel] = 1'b1;
  end

  always_comb begin
    cap      = '0;
    cap.v    = hit;
    cap.id   = sel;
    cap.a    = a[int'(sel)*WIDTH +: WIDTH];
    cap.b    = b[int'(sel)*WIDTH +: WIDTH];
    cap.acc  = accum[sel];
  end

  assign mul0 = PW'(st[0].a) * PW'(st[0].b);

  always_comb begin
    nx[0] = cap;
    for (int i = 1; i < NS; i++) begin
      nx[i] = st[i-1];
      if (i == 1) nx[i].prod = mul0;
    end
  end

  assign wb      = st[NS-1];
  assign wb_prod = (NS == 1) ? mul0 : wb.prod;

  // Read-modify-write only here, so same-id ops chain without bubbles.
  assign acc_new = wb.acc ? acc[wb.id] + ACCW'(wb_prod)
                          : ACCW'(wb_prod);

  always_comb begin
    busy = rsp_valid;
    for (int i = 0; i < NS; i++) busy = busy | st[i].v;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_acc     <= '0;
      for (int i = 0; i < NS; i++) st[i] <= '0;
      for (int j = 0; j < N_REQ; j++) acc[j] <= '0;
    end else begin
      if (hit) begin
        if (sel == IDW'(N_REQ - 1)) ptr <= '0;
        else                        ptr <= sel + 1'b1;
      end
      for (int i = 0; i < NS; i++) st[i] <= nx[i];
      rsp_valid <= wb.v;
      if (wb.v) begin
        rsp_id      <= wb.id;
        rsp_product <= wb_prod;
        rsp_acc     <= acc_new;
        acc[wb.id]  <= acc_new;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter against a
// queue-based transaction model of arbitration and accumulation.
module tb_mult_share_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int PIPE  = 3;
  localparam int ACCW  = 20;
  localparam int AMOD  = 1 << ACCW;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a;
  logic [N*W-1:0]  b;
  logic [N-1:0]    accum;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_product;
  logic [ACCW-1:0] rsp_acc;

  logic [W-1:0] av [N];
  logic [W-1:0] bv [N];

  mult_share_arbiter #(
    .N_REQ(N), .WIDTH(W), .PIPE(PIPE), .ACCW(ACCW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .a(a),
    .b(b),
    .accum(accum),
    .gnt(gnt),
    .busy(busy),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_product(rsp_product),
    .rsp_acc(rsp_acc)
  );

  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = av[i];
      b[i*W +: W] = bv[i];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    int x;
    int y;
    bit add;
    int due;
  } op_t;

  op_t q[$];
  int  macc [N];
  int  mptr;
  int  lid, lprod, lacc;
  int  cyc;
  int  n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mptr  = 0;
    lid   = 0;
    lprod = 0;
    lacc  = 0;
    for (int i = 0; i < N; i++) macc[i] = 0;
  endtask

  // Inputs are set after the previous rising edge; checks on the falling edge.
  task automatic step();
    int  eg, p, egv;
    bit  ev, eb;
    op_t op;
    @(negedge clk);
    if (!reset_n) begin
      model_reset();
      chk("rst_gnt",   32'(gnt), 0);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_id",    32'(rsp_id), 0);
      chk("rst_prod",  32'(rsp_product), 0);
      chk("rst_acc",   32'(rsp_acc), 0);
    end else begin
      eg = -1;
      for (int k = 0; k < N; k++) begin
        p = (mptr + k) % N;
        if (eg < 0 && req[p]) eg = p;
      end
      egv = (eg < 0) ? 0 : (1 << eg);
      chk("gnt", 32'(gnt), 32'(egv));
      eb = (q.size() != 0);
      ev = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
        op    = q.pop_front();
        ev    = 1'b1;
        lprod = op.x * op.y;
        if (op.add) macc[op.id] = (macc[op.id] + lprod) % AMOD;
        else        macc[op.id] = lprod;
        lid   = op.id;
        lacc  = macc[op.id];
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_id",    32'(rsp_id), 32'(lid));
      chk("rsp_prod",  32'(rsp_product), 32'(lprod));
      chk("rsp_acc",   32'(rsp_acc), 32'(lacc));
      chk("busy",      32'(busy), 32'(eb));
      if (eg >= 0) begin
        q.push_back('{eg, int'(av[eg]), int'(bv[eg]),
                     bit'(accum[eg]), cyc + PIPE});
        mptr = (eg + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_cycle();
    reset_n = 1'b0;
    req     = '0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    reset_n = 1'b1;
    req     = '0;
    accum   = '0;
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    model_reset();
    #1 reset_n = 1'b0;

    // reset then single load op
    step();
    step();
    reset_n  = 1'b1;
    req      = 4'b0001;
    av[0]    = 8'd12;
    bv[0]    = 8'd10;
    accum[0] = 1'b0;
    step();
    idle(5);
    chk("single_prod", 32'(rsp_product), 120);
    chk("single_acc",  32'(rsp_acc), 120);

    // round-robin with all requesting from pointer 0
    reset_cycle();
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        av[i]    = W'($urandom);
        bv[i]    = W'($urandom);
        accum[i] = 1'($urandom);
      end
      step();
    end
    idle(5);
    chk("rr_last_id", 32'(rsp_id), 3);

    // back-to-back accumulate on requester 2
    req   = 4'b0100;
    av[2] = 8'd255;
    bv[2] = 8'd255;
    for (int c = 0; c < 4; c++) begin
      accum[2] = (c != 0);
      step();
    end
    idle(5);
    chk("b2b_acc", 32'(rsp_acc), 260100);

    // preload acc1 to 1040000 = 20 * 208*250, then wrap
    req = 4'b0010;
    av[1] = 8'd208;
    bv[1] = 8'd250;
    for (int c = 0; c < 20; c++) begin
      accum[1] = (c != 0);
      step();
    end
    av[1]    = 8'd255;
    bv[1]    = 8'd255;
    accum[1] = 1'b1;
    step();
    idle(5);
    chk("wrap_acc", 32'(rsp_acc), 56449);

    // reset with ops in flight
    req = 4'b1111;
    for (int c = 0; c < 3; c++) step();
    reset_cycle();
    req = 4'b1111;
    #1;
    chk("post_rst_gnt", 32'(gnt), 1);
    step();
    req      = 4'b1000;
    av[3]    = 8'd3;
    bv[3]    = 8'd4;
    accum[3] = 1'b1;
    step();
    idle(5);
    chk("post_rst_acc", 32'(rsp_acc), 12);

    // withdrawn request, pointer holds at 2
    reset_cycle();
    req = 4'b0110;
    step();
    idle(2);
    req = 4'b0001;
    #1;
    chk("withdraw_gnt", 32'(gnt), 1);
    step();
    req = 4'b1111;
    step();
    idle(5);

    // random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_cycle();
      end else begin
        req = N'($urandom);
        for (int i = 0; i < N; i++) begin
          av[i]    = W'($urandom);
          bv[i]    = W'($urandom);
          accum[i] = ($urandom_range(0, 3) != 0);
        end
        step();
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
